ibex_instr_compressor: RTL and testbench

IBEX_INSTR_COMPRESSOR -- requirements
Module: ibex_instr_compressor

---
 rtl/ibex_pkg.sv | 28 ++
 rtl/ibex_compress_fn.sv | 96 +++++++++
 rtl/ibex_instr_compressor.sv | 108 ++++++++++
 tb/tb_ibex_instr_compressor.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared opcode enum, packer state and compressed-instruction constants.
package ibex_pkg;

   typedef enum logic [6:0] {
      OPCODE_LOAD     = 7'h03,
      OPCODE_MISC_MEM = 7'h0f,
      OPCODE_OP_IMM   = 7'h13,
      OPCODE_AUIPC    = 7'h17,
      OPCODE_STORE    = 7'h23,
      OPCODE_OP       = 7'h33,
      OPCODE_LUI      = 7'h37,
      OPCODE_BRANCH   = 7'h63,
      OPCODE_JALR     = 7'h67,
      OPCODE_JAL      = 7'h6f,
      OPCODE_SYSTEM   = 7'h73
   } opcode_e;

   typedef enum logic {
      PACK_EMPTY = 1'b0,
      PACK_HALF  = 1'b1
   } pack_state_e;

   // c.li x0,0 is a hint: harmless filler for the upper half of a flushed word.
   localparam logic [15:0] CNOP_HINT    = 16'h4001;
   localparam logic [15:0] CEBREAK      = 16'h9002;
   localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

endpackage

// File: rtl/ibex_compress_fn.sv
// Combinational RV32I -> RVC mapping. Only forms whose expansion is exact
// are compressed; c.addi/c.nop and PC-relative forms are never produced.
module ibex_compress_fn
   import ibex_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [15:0] cinstr_o,
   output logic        compressible_o
);

   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [11:0] imm_i, imm_s;
   logic        sp_range_i, sp_range_s, c_range_i, c_range_s, li_range;
   logic        rd_c, rs1_c, rs2_c;

   assign rd     = instr_i[11:7];
   assign rs1    = instr_i[19:15];
   assign rs2    = instr_i[24:20];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];
   assign imm_i  = instr_i[31:20];
   assign imm_s  = {instr_i[31:25], instr_i[11:7]};

   // word-aligned, non-negative offsets within the 8-bit (sp) or 7-bit (reg) window
   assign sp_range_i = (imm_i[11:8] == 4'd0) && (imm_i[1:0] == 2'd0);
   assign sp_range_s = (imm_s[11:8] == 4'd0) && (imm_s[1:0] == 2'd0);
   assign c_range_i  = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'd0);
   assign c_range_s  = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'd0);
   assign li_range   = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);

   assign rd_c  = (rd[4:3]  == 2'b01);
   assign rs1_c = (rs1[4:3] == 2'b01);
   assign rs2_c = (rs2[4:3] == 2'b01);

   // Select the compressed encoding; zero/non-compressible by default.
   always_comb begin
      cinstr_o       = 16'h0000;
      compressible_o = 1'b0;
      if (instr_i == EBREAK_INSTR) begin
         cinstr_o       = CEBREAK;
         compressible_o = 1'b1;
      end else if (instr_i[1:0] == 2'b11) begin
         case (instr_i[6:0])
            OPCODE_LOAD: begin
               if (funct3 == 3'b010) begin
                  if (rs1 == 5'd2 && rd != 5'd0 && sp_range_i) begin
                     cinstr_o       = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
                     compressible_o = 1'b1;
                  end else if (rd_c && rs1_c && c_range_i) begin
                     cinstr_o       = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
                     compressible_o = 1'b1;
                  end
               end
            end
            OPCODE_STORE: begin
               if (funct3 == 3'b010) begin
                  if (rs1 == 5'd2 && sp_range_s) begin
                     cinstr_o       = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
                     compressible_o = 1'b1;
                  end else if (rs2_c && rs1_c && c_range_s) begin
                     cinstr_o       = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
                     compressible_o = 1'b1;
                  end
               end
            end
            OPCODE_OP_IMM: begin
               if (funct3 == 3'b000 && rs1 == 5'd0 && rd != 5'd0 && li_range) begin
                  cinstr_o       = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
                  compressible_o = 1'b1;
               end
            end
            OPCODE_OP: begin
               if (funct3 == 3'b000 && funct7 == 7'd0 && rd != 5'd0 && rs2 != 5'd0) begin
                  if (rs1 == 5'd0) begin
                     cinstr_o       = {4'b1000, rd, rs2, 2'b10};
                     compressible_o = 1'b1;
                  end else if (rs1 == rd) begin
                     cinstr_o       = {4'b1001, rd, rs2, 2'b10};
                     compressible_o = 1'b1;
                  end
               end
            end
            OPCODE_JALR: begin
               if (funct3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0 && rd[4:1] == 4'd0) begin
                  cinstr_o       = {3'b100, rd[0], rs1, 5'd0, 2'b10};
                  compressible_o = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ibex_instr_compressor.sv
// Packs a stream of RV32I instructions into little-endian 32-bit fetch words,
// compressing where possible.
//
//   state      | meaning
//   PACK_EMPTY | no halfword pending; next word starts on a word boundary
//   PACK_HALF  | hold_q carries a halfword waiting for the upper slot
module ibex_instr_compressor
   import ibex_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] in_instr_i,
   input  logic        flush_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_data_o,
   output logic        idle_o,
   output logic [15:0] comp_cnt_o
);

   pack_state_e state_q, state_d;
   logic [15:0] hold_q, hold_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_data_q, out_data_d;
   logic [15:0] comp_cnt_q, comp_cnt_d;

   logic [15:0] cinstr;
   logic        compressible;
   logic        slot_free, accept;

   ibex_compress_fn u_compress_fn (
      .instr_i        (in_instr_i),
      .cinstr_o       (cinstr),
      .compressible_o (compressible)
   );

   assign slot_free  = !out_valid_q || out_ready_i;
   assign in_ready_o = slot_free && !flush_i;
   assign accept     = in_valid_i && in_ready_o;

   // Next-state, hold and output-slot update; flush wins over input.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      comp_cnt_d  = comp_cnt_q;

      if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end

      if (flush_i && slot_free) begin
         if (state_q == PACK_HALF) begin
            out_valid_d = 1'b1;
            out_data_d  = {CNOP_HINT, hold_q};
            state_d     = PACK_EMPTY;
         end
      end else if (accept) begin
         if (compressible) begin
            if (comp_cnt_q != 16'hFFFF) begin
               comp_cnt_d = comp_cnt_q + 16'd1;
            end
            if (state_q == PACK_EMPTY) begin
               hold_d  = cinstr;
               state_d = PACK_HALF;
            end else begin
               out_valid_d = 1'b1;
               out_data_d  = {cinstr, hold_q};
               state_d     = PACK_EMPTY;
            end
         end else if (state_q == PACK_EMPTY) begin
            out_valid_d = 1'b1;
            out_data_d  = in_instr_i;
         end else begin
            // a 32-bit instruction straddles the word boundary
            out_valid_d = 1'b1;
            out_data_d  = {in_instr_i[15:0], hold_q};
            hold_d      = in_instr_i[31:16];
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= PACK_EMPTY;
         hold_q      <= 16'h0000;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'h0000_0000;
         comp_cnt_q  <= 16'h0000;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         comp_cnt_q  <= comp_cnt_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign idle_o      = (state_q == PACK_EMPTY) && !out_valid_q;
   assign comp_cnt_o  = comp_cnt_q;

endmodule

// File: tb/tb_ibex_instr_compressor.sv
// Bench for ibex_instr_compressor: directed scenarios plus a random stream whose
// output halfwords are expanded back and compared in order with the input.
module tb_ibex_instr_compressor;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = 32'h0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b1;
   logic        in_ready_o, out_valid_o, idle_o;
   logic [31:0] out_data_o;
   logic [15:0] comp_cnt_o;

   ibex_instr_compressor dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready_o),
      .in_instr_i  (in_instr),
      .flush_i     (flush),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready),
      .out_data_o  (out_data_o),
      .idle_o      (idle_o),
      .comp_cnt_o  (comp_cnt_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
      logic [31:0] a, b, c, d, e;
      a = imm; b = rs1; c = f3; d = rd; e = op;
      return {a[11:0], b[4:0], c[2:0], d[4:0], e[6:0]};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3, input int op);
      logic [31:0] a, b, c, d, e;
      a = imm; b = rs2; c = rs1; d = f3; e = op;
      return {a[11:5], b[4:0], c[4:0], d[2:0], a[4:0], e[6:0]};
   endfunction

   function automatic logic [31:0] enc_r(input int rs2, input int rs1, input int rd, input int op);
      logic [31:0] b, c, d, e;
      b = rs2; c = rs1; d = rd; e = op;
      return {7'd0, b[4:0], c[4:0], 3'd0, d[4:0], e[6:0]};
   endfunction

   // Should this RV32I word be emitted as a halfword?
   function automatic bit pred(input logic [31:0] w);
      int op, rd, rs1, rs2, f3, f7, ii, si;
      if (w == 32'h0010_0073) return 1'b1;
      if (w[1:0] != 2'b11) return 1'b0;
      op = int'(w[6:0]); rd = int'(w[11:7]); rs1 = int'(w[19:15]); rs2 = int'(w[24:20]);
      f3 = int'(w[14:12]); f7 = int'(w[31:25]);
      ii = int'($signed(w[31:20]));
      si = int'($signed({w[31:25], w[11:7]}));
      if (op == 3 && f3 == 2) begin
         if (rs1 == 2 && rd != 0 && ii % 4 == 0 && ii >= 0 && ii <= 252) return 1'b1;
         if (rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15 && ii % 4 == 0 && ii >= 0 && ii <= 124) return 1'b1;
      end
      if (op == 35 && f3 == 2) begin
         if (rs1 == 2 && si % 4 == 0 && si >= 0 && si <= 252) return 1'b1;
         if (rs2 >= 8 && rs2 <= 15 && rs1 >= 8 && rs1 <= 15 && si % 4 == 0 && si >= 0 && si <= 124) return 1'b1;
      end
      if (op == 19 && f3 == 0 && rs1 == 0 && rd != 0 && ii >= -32 && ii <= 31) return 1'b1;
      if (op == 51 && f3 == 0 && f7 == 0 && rd != 0 && rs2 != 0 && (rs1 == 0 || rs1 == rd)) return 1'b1;
      if (op == 103 && f3 == 0 && ii == 0 && rs1 != 0 && rd <= 1) return 1'b1;
      return 1'b0;
   endfunction

   // Compressed decoder for the forms this block may emit.
   function automatic logic [31:0] expand(input logic [15:0] h);
      int rd, r2, u, v;
      logic [2:0] f3;
      f3 = h[15:13]; rd = int'(h[11:7]); r2 = int'(h[6:2]);
      if (h[1:0] == 2'b10) begin
         if (f3 == 3'b010) begin
            u = int'(h[3:2]) * 64 + int'(h[12]) * 32 + int'(h[6:4]) * 4;
            return enc_i(u, 2, 2, rd, 3);
         end
         if (f3 == 3'b110) begin
            u = int'(h[8:7]) * 64 + int'(h[12:9]) * 4;
            return enc_s(u, r2, 2, 2, 35);
         end
         if (f3 == 3'b100) begin
            if (!h[12]) begin
               if (r2 == 0) return enc_i(0, rd, 0, 0, 103);
               return enc_r(r2, 0, rd, 51);
            end
            if (rd == 0 && r2 == 0) return 32'h0010_0073;
            if (r2 == 0) return enc_i(0, rd, 0, 1, 103);
            return enc_r(r2, rd, rd, 51);
         end
      end else if (h[1:0] == 2'b00) begin
         u = int'(h[5]) * 64 + int'(h[12:10]) * 8 + int'(h[6]) * 4;
         if (f3 == 3'b010) return enc_i(u, 8 + int'(h[9:7]), 2, 8 + int'(h[4:2]), 3);
         if (f3 == 3'b110) return enc_s(u, 8 + int'(h[4:2]), 8 + int'(h[9:7]), 2, 35);
      end else if (h[1:0] == 2'b01 && f3 == 3'b010) begin
         v = r2 - (h[12] ? 32 : 0);
         return enc_i(v, 0, 0, rd, 19);
      end
      return 32'h0000_0000;
   endfunction

   function automatic int pick_imm();
      case ($urandom_range(0, 5))
         0: return 4 * $urandom_range(0, 31);
         1: return 4 * $urandom_range(28, 66);
         2: return 252;
         3: return 124 + 4 * $urandom_range(0, 1);
         4: return 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
         default: return int'($urandom_range(0, 2047)) - 1024;
      endcase
   endfunction

   function automatic logic [31:0] gen();
      int rd, rs1, rs2;
      rd = $urandom_range(0, 31); rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31);
      case ($urandom_range(0, 11))
         0: return enc_i(pick_imm(), 2, 2, $urandom_range(0, 3) == 0 ? 0 : rd, 3);
         1: return enc_s(pick_imm(), rs2, 2, 2, 35);
         2: return enc_i(pick_imm(), $urandom_range(6, 17), 2, $urandom_range(6, 17), 3);
         3: return enc_s(pick_imm(), $urandom_range(6, 17), $urandom_range(6, 17), 2, 35);
         4: return enc_i(int'($urandom_range(0, 80)) - 40, $urandom_range(0, 2) == 0 ? rs1 : 0,
                         0, $urandom_range(0, 5) == 0 ? 0 : rd, 19);
         5: return enc_r($urandom_range(0, 4) == 0 ? 0 : rs2, 0, $urandom_range(0, 4) == 0 ? 0 : rd, 51);
         6: return enc_r(rs2, $urandom_range(0, 1) == 0 ? rd : rs1, rd, 51);
         7: return enc_i($urandom_range(0, 3) == 0 ? 4 : 0, $urandom_range(0, 4) == 0 ? 0 : rs1,
                         0, $urandom_range(0, 2), 103);
         8: return $urandom_range(0, 1) ? 32'h0010_0073 : 32'h0000_0073;
         9: return {$urandom_range(0, 20'hFFFFF) & 32'hFFFFF, rd[4:0], 7'h6f} ;
         10: return $urandom_range(0, 1) ? enc_s(2 * $urandom_range(0, 1000), rs2, rs1, 0, 99)
                                         : {$urandom_range(0, 20'hFFFFF) & 32'hFFFFF, rd[4:0], 7'h17};
         default: return {$urandom_range(0, 20'hFFFFF) & 32'hFFFFF, rd[4:0], 7'h37};
      endcase
   endfunction

   // ---------------- monitor / scoreboard ----------------
   typedef struct { bit mark; logic [31:0] w; } exp_t;
   exp_t        exp_q[$];
   logic [15:0] hq[$];
   logic [31:0] wlog[$];
   bit          m_half = 1'b0;
   int unsigned m_cnt = 0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_data = 32'h0;

   // Check handshake/idle/count every cycle and reconcile the output halfword stream.
   always @(negedge clk) begin
      exp_t        e;
      logic [15:0] h;
      logic [31:0] w;
      if (!rst_ni) begin
         exp_q.delete(); hq.delete();
         m_half = 1'b0; m_cnt = 0; prev_stall = 1'b0;
      end else begin
         chk("in_ready", {31'd0, in_ready_o}, {31'd0, (!out_valid_o || out_ready) && !flush});
         chk("idle", {31'd0, idle_o}, {31'd0, !m_half && !out_valid_o});
         chk("comp_cnt", {16'd0, comp_cnt_o}, m_cnt);
         if (prev_stall) begin
            chk("stall_valid", {31'd0, out_valid_o}, 32'd1);
            chk("stall_data", out_data_o, prev_data);
         end
         prev_stall = out_valid_o && !out_ready;
         prev_data  = out_data_o;
         if (out_valid_o && out_ready) begin
            hq.push_back(out_data_o[15:0]);
            hq.push_back(out_data_o[31:16]);
            wlog.push_back(out_data_o);
         end
         if (in_valid && in_ready_o) begin
            e.mark = 1'b0; e.w = in_instr;
            exp_q.push_back(e);
            if (pred(in_instr)) begin
               m_half = !m_half;
               if (m_cnt < 65535) m_cnt++;
            end
         end else if (flush && (!out_valid_o || out_ready) && m_half) begin
            e.mark = 1'b1; e.w = 32'h0;
            exp_q.push_back(e);
            m_half = 1'b0;
         end
         while (exp_q.size() > 0) begin
            e = exp_q[0];
            if (e.mark || pred(e.w)) begin
               if (hq.size() < 1) break;
               h = hq.pop_front();
               void'(exp_q.pop_front());
               if (e.mark) chk("flush_hint", {16'd0, h}, 32'h4001);
               else        chk("cinstr_expand", expand(h), e.w);
            end else begin
               if (hq.size() < 2) break;
               w = {hq[1], hq[0]};
               void'(hq.pop_front()); void'(hq.pop_front());
               void'(exp_q.pop_front());
               chk("word32", w, e.w);
            end
         end
         if (exp_q.size() == 0 && hq.size() > 0) begin
            chk("extra_halfwords", hq.size(), 0);
            hq.delete();
         end
      end
   end

   bit bp_en = 1'b0;
   // Random backpressure during the random phase.
   always @(posedge clk) begin
      if (bp_en) begin
         #1 out_ready = ($urandom_range(0, 99) < 60);
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [31:0] w);
      int n = 0;
      in_instr = w; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready_o && n < 200) begin n++; @(negedge clk); end
      if (n >= 200) begin
         vectors++; miscompares++;
         $display("FAIL send_timeout: in_ready_o stuck low, instr %08h", w);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic flush_drain();
      int n = 0;
      flush = 1'b1;
      @(negedge clk);
      while (!idle_o && n < 200) begin n++; @(negedge clk); end
      if (n >= 200) begin
         vectors++; miscompares++;
         $display("FAIL flush_timeout: idle_o stuck low");
      end
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic wait_words(input int n);
      int k = 0;
      while (wlog.size() < n && k < 200) begin k++; @(posedge clk); end
      if (k > 0) #1;
      if (k >= 200) begin
         vectors++; miscompares++;
         $display("FAIL word_timeout: have %0d words need %0d", wlog.size(), n);
      end
   endtask

   initial begin
      int base;
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst_out_data", out_data_o, 32'd0);
      chk("rst_comp_cnt", {16'd0, comp_cnt_o}, 32'd0);
      chk("rst_idle", {31'd0, idle_o}, 32'd1);
      chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
      @(posedge clk); #1 rst_ni = 1'b1;

      // pin the model itself
      chk("pin_expand_clw", expand(16'h4504), 32'h0085_2483);
      chk("pin_expand_cmv", expand(16'h829A), 32'h0060_02B3);
      chk("pin_pred_lw", {31'd0, pred(32'h0085_2483)}, 32'd1);
      chk("pin_pred_jal", {31'd0, pred(32'h1000_00EF)}, 32'd0);

      // lw into c.lw, then flush pads with the hint
      base = wlog.size();
      send(32'h0085_2483);
      flush_drain();
      wait_words(base + 1);
      chk("lw_flush_word", wlog[base], 32'h4001_4504);
      @(negedge clk);
      chk("lw_flush_cnt", {16'd0, comp_cnt_o}, 32'd1);
      chk("lw_flush_idle", {31'd0, idle_o}, 32'd1);
      tick();

      // two compressed halves fill one word
      base = wlog.size();
      send(32'h0010_0073);
      send(32'h0060_02B3);
      wait_words(base + 1);
      chk("ebreak_mv_word", wlog[base], 32'h829A_9002);

      // 32-bit instruction straddles the word boundary
      base = wlog.size();
      send(32'h0010_0073);
      send(32'h1000_00EF);
      flush_drain();
      wait_words(base + 2);
      chk("straddle_word0", wlog[base], 32'h00EF_9002);
      chk("straddle_word1", wlog[base + 1], 32'h4001_1000);

      // low bits != 2'b11 pass through untouched
      base = wlog.size();
      send(32'h0085_2480);
      wait_words(base + 1);
      chk("passthru_word", wlog[base], 32'h0085_2480);

      // output backpressure
      out_ready = 1'b0;
      send(32'h1000_00EF);
      repeat (3) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, out_valid_o}, 32'd1);
         chk("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
         chk("bp_data", out_data_o, 32'h1000_00EF);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", {31'd0, in_ready_o}, 32'd1);
      tick();

      // reset mid-operation drops the pending halfword and the stalled word
      out_ready = 1'b0;
      send(32'h0010_0073);
      send(32'h1000_00EF);
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_idle", {31'd0, idle_o}, 32'd1);
      chk("midrst_valid", {31'd0, out_valid_o}, 32'd0);
      chk("midrst_cnt", {16'd0, comp_cnt_o}, 32'd0);
      tick();
      base = wlog.size();
      flush = 1'b1;
      repeat (4) tick();
      flush = 1'b0;
      repeat (2) tick();
      chk("midrst_flush_nothing", wlog.size(), base);

      // random stream with random backpressure and occasional flushes
      bp_en = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
         if ($urandom_range(0, 29) == 0) begin
            if ($urandom_range(0, 1)) begin in_valid = 1'b1; in_instr = gen(); end
            flush_drain();
            in_valid = 1'b0;
         end
         send(gen());
      end
      bp_en = 1'b0;
      tick();
      out_ready = 1'b1;
      flush_drain();
      repeat (3) tick();
      chk("drain_exp_empty", exp_q.size(), 0);
      chk("drain_hq_empty", hq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
